// File: rtl/time_setter_if.sv
// ---------------------------------------------------------------------------
// time_setter_if : load-request channel from the time setter to the clock core.
//
// Handshake: the master raises ld_valid together with a payload (ld_sel,
// ld_value) and then holds ld_valid high and the payload constant until a
// clock edge at which ld_valid & ld_ready are both high. That edge is the
// single transfer. The slave may drive ld_ready at any time, including high
// before ld_valid rises; ld_ready has no effect while ld_valid is low.
//
// Signals
//   ld_valid  master->slave  load request pending
//   ld_sel    master->slave  0 = minute field, 1 = hour field
//   ld_value  master->slave  clamped field value
//   ld_ready  slave->master  request accepted when ld_valid & ld_ready
// ---------------------------------------------------------------------------
interface time_setter_if;
    logic       ld_valid;
    logic       ld_sel;
    logic [5:0] ld_value;
    logic       ld_ready;

    modport master (output ld_valid, output ld_sel, output ld_value, input ld_ready);
    modport slave  (input ld_valid, input ld_sel, input ld_value, output ld_ready);
endinterface

// File: rtl/time_setter.sv
// ---------------------------------------------------------------------------
// time_setter : turns raw hour/minute pushbuttons plus a 6-bit switch value
// into clamped hour/minute load requests for the clock core.
//
// Each active-low button is synchronised (2 FFs), debounced, and
// edge-detected. A press in IDLE captures the field select and the clamped
// switch value, then one request is offered on the ld channel. After the
// transfer the block waits until both buttons are released.
//
// Optional feature (macro AUTOREPEAT_EN): while the button that caused the
// load stays pressed in WAIT_REL, a new load of the same field is issued
// every REPEAT_CYCLES cycles. Without the macro the repeat counter is absent.
//
// Ports
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   btn_h_n   in   raw hour-set button, active-low, asynchronous
//   btn_m_n   in   raw minute-set button, active-low, asynchronous
//   value     in   switch value, sampled at capture time
//   ld        --   load channel (master side): ld_valid/ld_sel/ld_value/ld_ready
//   clamped   out  sticky: last captured value was clamped
//   state_o   out  FSM state (0 IDLE, 1 LOAD, 2 WAIT_REL)
// ---------------------------------------------------------------------------
module time_setter #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_h_n,
    input  logic                btn_m_n,
    input  logic [5:0]          value,
    time_setter_if.master       ld,
    output logic                clamped,
    output logic [1:0]          state_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    // Index 0 = minute button, index 1 = hour button; all levels active-low.
    logic [1:0]    raw_n;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    db_n_q;
    logic [1:0]    db_prev_q;
    logic [1:0]    press_q;
    logic [DW-1:0] db_cnt_q [2];

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic [5:0]    val_q, val_d;
    logic          clamped_q, clamped_d;

    assign raw_n = {btn_h_n, btn_m_n};

    // Synchroniser, debouncer and press detector for both buttons.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            db_n_q    <= 2'b11;
            db_prev_q <= 2'b11;
            press_q   <= 2'b00;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q   <= raw_n;
            sync2_q   <= sync1_q;
            db_prev_q <= db_n_q;
            // released (1) -> pressed (0) transition of the debounced level
            press_q   <= db_prev_q & ~db_n_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] != db_n_q[i]) begin
                    if (db_cnt_q[i] == DB_LAST) begin
                        db_n_q[i]   <= sync2_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    // Returns {was_clamped, clamped_value} for the selected field.
    function automatic logic [6:0] clamp_f(input logic sel, input logic [5:0] v);
        logic [5:0] limit;
        limit = sel ? 6'd23 : 6'd59;
        return (v > limit) ? {1'b1, limit} : {1'b0, v};
    endfunction

`ifdef AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt_q;
    logic          held;

    // Only the button that caused the current load keeps the repeat going.
    assign held = ~db_n_q[sel_q];

    always_ff @(posedge clk) begin
        if (reset || state_q != WAIT_REL || !held) begin
            rep_cnt_q <= '0;
        end else if (rep_cnt_q == REP_LAST) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_q + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            val_q     <= '0;
            clamped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            val_q     <= val_d;
            clamped_q <= clamped_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        val_d     = val_q;
        clamped_d = clamped_q;
        case (state_q)
            IDLE: begin
                // Hour has priority; a simultaneous minute press is dropped.
                if (press_q[1]) begin
                    sel_d = 1'b1;
                    {clamped_d, val_d} = clamp_f(1'b1, value);
                    state_d = LOAD;
                end else if (press_q[0]) begin
                    sel_d = 1'b0;
                    {clamped_d, val_d} = clamp_f(1'b0, value);
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (ld.ld_ready) state_d = WAIT_REL;
            end
            WAIT_REL: begin
`ifdef AUTOREPEAT_EN
                if (held && rep_cnt_q == REP_LAST) begin
                    {clamped_d, val_d} = clamp_f(sel_q, value);
                    state_d = LOAD;
                end else if (db_n_q == 2'b11) begin
                    state_d = IDLE;
                end
`else
                if (db_n_q == 2'b11) state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign ld.ld_valid = (state_q == LOAD);
    assign ld.ld_sel   = sel_q;
    assign ld.ld_value = val_q;
    assign clamped     = clamped_q;
    assign state_o     = state_q;

endmodule
